// File: rtl/adc_packet_framer.sv
// Frames ADC AXI-Stream packets with a MAGIC/seq header and a {ovf, count} trailer.
// Define ADC_FRAMER_TIMESTAMP_EN to add a timestamp word to the header.
module adc_packet_framer #(
   parameter logic [31:0] MAGIC     = 32'hADC1_6A5A,
   parameter int unsigned MAX_BEATS = 4096
) (
   input  logic        s00_axis_aclk,
   input  logic        s00_axis_aresetn,
   input  logic        s00_axis_tvalid,
   input  logic [31:0] s00_axis_tdata,
   input  logic [3:0]  s00_axis_tkeep,
   input  logic        s00_axis_tlast,
   output logic        s00_axis_tready,
   output logic        m00_axis_tvalid,
   output logic [31:0] m00_axis_tdata,
   output logic [3:0]  m00_axis_tkeep,
   output logic        m00_axis_tlast,
   input  logic        m00_axis_tready,
   input  logic        framing_en,
   output logic        pkt_done,
   output logic        overflow
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StHdr0    = 3'd1,
      StHdr1    = 3'd2,
`ifdef ADC_FRAMER_TIMESTAMP_EN
      StHdr2    = 3'd3,
`endif
      StPayload = 3'd4,
      StDrop    = 3'd5,
      StTrl     = 3'd6,
      StBypass  = 3'd7
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] seq_q, seq_d;
   logic [31:0] cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic        overflow_q, overflow_d;
   logic        trl_sent_q, trl_sent_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_last_q, out_last_d;
   logic        load;
   logic        s_ready;
   logic        s_acc;
   logic [31:0] cnt_inc;
   logic        unused_tkeep;

`ifdef ADC_FRAMER_TIMESTAMP_EN
   logic [31:0] ts_cnt_q;
   logic [31:0] ts_q, ts_d;
`endif

   assign unused_tkeep = ^s00_axis_tkeep;

   assign load    = !out_valid_q || m00_axis_tready;
   assign s_ready = ((state_q == StPayload) || (state_q == StBypass) || (state_q == StDrop)) &&
                    ((state_q == StDrop) || load);
   assign s_acc   = s00_axis_tvalid && s_ready;
   assign cnt_inc = cnt_q + 32'd1;

   always_comb begin
      state_d     = state_q;
      seq_d       = seq_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      overflow_d  = overflow_q;
      trl_sent_d  = trl_sent_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
`ifdef ADC_FRAMER_TIMESTAMP_EN
      ts_d        = ts_q;
`endif
      // Output register drains on acceptance unless something reloads it below.
      if (load) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (s00_axis_tvalid) begin
               if (framing_en) begin
`ifdef ADC_FRAMER_TIMESTAMP_EN
                  ts_d = ts_cnt_q;
`endif
                  state_d = StHdr0;
               end else begin
                  state_d = StBypass;
               end
            end
         end
         StHdr0: begin
            if (load) begin
               out_valid_d = 1'b1;
               out_data_d  = MAGIC;
               out_last_d  = 1'b0;
               state_d     = StHdr1;
            end
         end
         StHdr1: begin
            if (load) begin
               out_valid_d = 1'b1;
               out_data_d  = seq_q;
               out_last_d  = 1'b0;
`ifdef ADC_FRAMER_TIMESTAMP_EN
               state_d     = StHdr2;
`else
               state_d     = StPayload;
`endif
            end
         end
`ifdef ADC_FRAMER_TIMESTAMP_EN
         StHdr2: begin
            if (load) begin
               out_valid_d = 1'b1;
               out_data_d  = ts_q;
               out_last_d  = 1'b0;
               state_d     = StPayload;
            end
         end
`endif
         StPayload: begin
            if (s_acc) begin
               out_valid_d = 1'b1;
               out_data_d  = s00_axis_tdata;
               out_last_d  = 1'b0;
               cnt_d       = cnt_inc;
               if (s00_axis_tlast) begin
                  state_d = StTrl;
               end else if (cnt_inc == MAX_BEATS) begin
                  ovf_d      = 1'b1;
                  overflow_d = 1'b1;
                  state_d    = StDrop;
               end
            end
         end
         StDrop: begin
            if (s_acc && s00_axis_tlast) begin
               state_d = StTrl;
            end
         end
         StTrl: begin
            // Stay here until the trailer itself has been accepted downstream.
            if (!trl_sent_q) begin
               if (load) begin
                  out_valid_d = 1'b1;
                  out_data_d  = {ovf_q, cnt_q[30:0]};
                  out_last_d  = 1'b1;
                  trl_sent_d  = 1'b1;
               end
            end else if (m00_axis_tready) begin
               seq_d      = seq_q + 32'd1;
               cnt_d      = 32'd0;
               ovf_d      = 1'b0;
               trl_sent_d = 1'b0;
               state_d    = StIdle;
            end
         end
         StBypass: begin
            if (s_acc) begin
               out_valid_d = 1'b1;
               out_data_d  = s00_axis_tdata;
               out_last_d  = s00_axis_tlast;
               if (s00_axis_tlast) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (!s00_axis_aresetn) begin
         state_q     <= StIdle;
         seq_q       <= 32'd0;
         cnt_q       <= 32'd0;
         ovf_q       <= 1'b0;
         overflow_q  <= 1'b0;
         trl_sent_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'd0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         seq_q       <= seq_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         overflow_q  <= overflow_d;
         trl_sent_q  <= trl_sent_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

`ifdef ADC_FRAMER_TIMESTAMP_EN
   always_ff @(posedge s00_axis_aclk) begin
      if (!s00_axis_aresetn) begin
         ts_cnt_q <= 32'd0;
         ts_q     <= 32'd0;
      end else begin
         ts_cnt_q <= ts_cnt_q + 32'd1;
         ts_q     <= ts_d;
      end
   end
`endif

   assign s00_axis_tready = s_ready;
   assign m00_axis_tvalid = out_valid_q;
   assign m00_axis_tdata  = out_data_q;
   assign m00_axis_tlast  = out_last_q;
   assign m00_axis_tkeep  = 4'b1111;
   // The only tlast words are trailers (framed) or copied tlast beats (bypass).
   assign pkt_done        = out_valid_q && out_last_q && m00_axis_tready;
   assign overflow        = overflow_q;

endmodule

// File: tb/tb_adc_packet_framer.sv
// Directed bench for adc_packet_framer (MAX_BEATS=8); follows ADC_FRAMER_TIMESTAMP_EN if defined.
module tb_adc_packet_framer;

   logic        aclk;
   logic        aresetn;
   logic        s_tvalid;
   logic [31:0] s_tdata;
   logic [3:0]  s_tkeep;
   logic        s_tlast;
   logic        s_tready;
   logic        m_tvalid;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tlast;
   logic        m_tready;
   logic        framing_en;
   logic        pkt_done;
   logic        overflow;

   int          n_checks = 0;
   int          n_err = 0;
   logic [31:0] tb_seq = 32'd0;
   logic [15:0] pat = 16'b1011_0010_1101_1001;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic        got_last_q[$];

`ifdef ADC_FRAMER_TIMESTAMP_EN
   logic [31:0] tb_ts = 32'd0;
   always @(posedge aclk) begin
      if (!aresetn) tb_ts <= 32'd0;
      else          tb_ts <= tb_ts + 32'd1;
   end
`endif

   adc_packet_framer #(
      .MAX_BEATS(8)
   ) dut (
      .s00_axis_aclk   (aclk),
      .s00_axis_aresetn(aresetn),
      .s00_axis_tvalid (s_tvalid),
      .s00_axis_tdata  (s_tdata),
      .s00_axis_tkeep  (s_tkeep),
      .s00_axis_tlast  (s_tlast),
      .s00_axis_tready (s_tready),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tkeep  (m_tkeep),
      .m00_axis_tlast  (m_tlast),
      .m00_axis_tready (m_tready),
      .framing_en      (framing_en),
      .pkt_done        (pkt_done),
      .overflow        (overflow)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Sends one packet of n beats (base+i) and checks the framed output; called at posedge+1.
   task automatic run_packet(input string name, input int n, input bit fr, input bit toggle,
                             input bit flip, input int abort_at, input logic [31:0] base);
      int          idx;
      int          cyc;
      int          pulses;
      int          first_v;
      bit          done;
      bit          aborted;
      bit          prev_stall;
      bit          in_hs;
      logic [31:0] prev_data;
      logic        prev_last;
      idx = 0; cyc = 0; pulses = 0; first_v = -1;
      done = 1'b0; aborted = 1'b0; prev_stall = 1'b0;
      prev_data = 32'd0; prev_last = 1'b0;
      got_q.delete(); got_last_q.delete(); exp_q.delete();
      if (fr) begin
         exp_q.push_back(32'hADC1_6A5A);
         exp_q.push_back(tb_seq);
`ifdef ADC_FRAMER_TIMESTAMP_EN
         exp_q.push_back(tb_ts);
`endif
      end
      for (int i = 0; i < n && i < 8; i++) exp_q.push_back(base + 32'(i));
      if (fr) exp_q.push_back((n > 8) ? 32'h8000_0008 : 32'(n));

      framing_en = fr;
      s_tvalid   = 1'b1;
      s_tdata    = base;
      s_tlast    = (n == 1);
      m_tready   = toggle ? pat[0] : 1'b1;

      while (!done && !aborted && cyc < 200) begin
         @(negedge aclk);
         in_hs = s_tvalid && s_tready;
         if (prev_stall) begin
            check({name, " stall_valid"}, 32'(m_tvalid), 32'd1);
            check({name, " stall_data"}, m_tdata, prev_data);
            check({name, " stall_last"}, 32'(m_tlast), 32'(prev_last));
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
         if (m_tvalid && first_v < 0) first_v = cyc;
         if (pkt_done) pulses++;
         if (m_tvalid && m_tready) begin
            got_q.push_back(m_tdata);
            got_last_q.push_back(m_tlast);
            if (m_tlast) done = 1'b1;
         end
         @(posedge aclk);
         #1;
         cyc++;
         if (abort_at != 0 && cyc == abort_at) begin
            aresetn  = 1'b0;
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            @(posedge aclk);
            #1;
            check({name, " rst_m_tvalid"}, 32'(m_tvalid), 32'd0);
            check({name, " rst_s_tready"}, 32'(s_tready), 32'd0);
            check({name, " rst_overflow"}, 32'(overflow), 32'd0);
            check({name, " rst_pkt_done"}, 32'(pkt_done), 32'd0);
            aresetn = 1'b1;
            tb_seq  = 32'd0;
            aborted = 1'b1;
         end else begin
            if (in_hs) begin
               idx++;
               if (idx < n) begin
                  s_tdata = base + 32'(idx);
                  s_tlast = (idx == n - 1);
               end else begin
                  s_tvalid = 1'b0;
                  s_tlast  = 1'b0;
                  s_tdata  = 32'd0;
               end
            end
            if (flip && cyc == 1) framing_en = !fr;
            m_tready = toggle ? pat[cyc[3:0]] : 1'b1;
         end
      end

      if (!aborted) begin
         check({name, " finished"}, 32'(done), 32'd1);
         check({name, " beats_consumed"}, 32'(idx), 32'(n));
         check({name, " pkt_done_pulses"}, 32'(pulses), 32'd1);
         check({name, " first_valid_latency"}, 32'(first_v), 32'd2);
         check({name, " word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s word%0d", name, i), got_q[i], exp_q[i]);
            check($sformatf("%s last%0d", name, i), 32'(got_last_q[i]),
                  32'(i == exp_q.size() - 1));
         end
         if (fr) tb_seq = tb_seq + 32'd1;
      end
      m_tready = 1'b1;
   endtask

   initial begin
      aresetn    = 1'b0;
      s_tvalid   = 1'b0;
      s_tdata    = 32'd0;
      s_tkeep    = 4'b0000;
      s_tlast    = 1'b0;
      m_tready   = 1'b1;
      framing_en = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      check("reset m_tvalid", 32'(m_tvalid), 32'd0);
      check("reset m_tdata", m_tdata, 32'd0);
      check("reset m_tlast", 32'(m_tlast), 32'd0);
      check("reset m_tkeep", 32'(m_tkeep), 32'hF);
      check("reset s_tready", 32'(s_tready), 32'd0);
      check("reset pkt_done", 32'(pkt_done), 32'd0);
      check("reset overflow", 32'(overflow), 32'd0);
      aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      #1;

      run_packet("pktA", 4, 1'b1, 1'b0, 1'b0, 0, 32'hD000_0000);
      check("pktA overflow", 32'(overflow), 32'd0);
      run_packet("pktB", 4, 1'b1, 1'b1, 1'b1, 0, 32'hD000_0010);
      run_packet("pktC", 12, 1'b1, 1'b0, 1'b0, 0, 32'hD000_0100);
      check("pktC overflow", 32'(overflow), 32'd1);
      run_packet("pktD", 2, 1'b1, 1'b1, 1'b0, 0, 32'hD000_0110);
      check("pktD overflow_sticky", 32'(overflow), 32'd1);
      run_packet("pktE", 8, 1'b1, 1'b0, 1'b0, 0, 32'hD000_0120);
      run_packet("bypass", 3, 1'b0, 1'b1, 1'b0, 0, 32'hD000_0200);
      run_packet("pktG", 1, 1'b1, 1'b0, 1'b0, 0, 32'hD000_0300);
      run_packet("abort", 6, 1'b1, 1'b0, 1'b0, 6, 32'hD000_0400);
      run_packet("pktI", 1, 1'b1, 1'b0, 1'b0, 0, 32'hD000_0500);
      check("pktI overflow", 32'(overflow), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
